// File: rtl/fifo_uart_tx.sv
// UART transmitter that pulls bytes from an upstream synchronous FIFO.
// 8N1 framing with an optional even-parity bit; frames are counted modulo 256.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 8,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd,
  output logic       tx,
  output logic       busy,
  output logic       tx_done,
  output logic [7:0] frame_cnt
);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, START, DATA, PARITY, STOP} state_t;

  localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);

  state_t     state_q, state_d;
  logic [7:0] baud_cnt;
  logic [2:0] bit_idx;
  logic [7:0] sreg;
  logic       par;
  logic       timed, bit_end;

  assign timed   = (state_q == START) || (state_q == DATA) ||
                   (state_q == PARITY) || (state_q == STOP);
  assign bit_end = timed && (baud_cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (en && !fifo_empty) state_d = FETCH;
      FETCH:  state_d = WAIT;
      WAIT:   state_d = START;
      START:  if (bit_end) state_d = DATA;
      DATA:   if (bit_end && bit_idx == 3'd7) state_d = PARITY_EN ? PARITY : STOP;
      PARITY: if (bit_end) state_d = STOP;
      STOP:   if (bit_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Baud counter wraps on every bit boundary; leaving a timed state always
  // coincides with a boundary, so it is zero again on any state change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baud_cnt  <= '0;
      bit_idx   <= '0;
      sreg      <= '0;
      par       <= 1'b0;
      tx_done   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      baud_cnt <= (timed && !bit_end) ? baud_cnt + 8'd1 : 8'd0;
      tx_done  <= (state_q == STOP) && bit_end;
      if (state_q == WAIT) begin
        sreg    <= fifo_data;
        par     <= 1'b0;
        bit_idx <= '0;
      end else if (state_q == DATA && bit_end) begin
        sreg    <= sreg >> 1;
        par     <= par ^ sreg[0];
        bit_idx <= bit_idx + 3'd1;
      end
      if (state_q == STOP && bit_end) frame_cnt <= frame_cnt + 8'd1;
    end
  end

  always_comb begin
    tx = 1'b1;
    case (state_q)
      START:   tx = 1'b0;
      DATA:    tx = sreg[0];
      PARITY:  tx = par;
      default: tx = 1'b1;
    endcase
  end

  assign fifo_rd = (state_q == FETCH);
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances (parity off / on) fed by array FIFO models,
// frames checked cycle by cycle against a bit list built from the byte value.
module tb_fifo_uart_tx;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst, en;
  logic       fe0, fe1, rd0, rd1, tx0, tx1, busy0, busy1, done0, done1;
  logic [7:0] fd0, fd1, cnt0, cnt1;

  byte unsigned mem0 [1024];
  byte unsigned mem1 [1024];
  int wp0 = 0, wp1 = 0, rp0 = 0, rp1 = 0;

  int checks = 0, errors = 0;
  int exp_cnt [2];
  byte unsigned pend [$];
  bit   rand_en = 1'b0;
  bit   sel = 1'b0;
  logic tx_m, rd_m, busy_m, done_m;
  logic [7:0] cnt_m;

  fifo_uart_tx #(.CLKS_PER_BIT(N), .PARITY_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fe0), .fifo_data(fd0),
    .fifo_rd(rd0), .tx(tx0), .busy(busy0), .tx_done(done0), .frame_cnt(cnt0));

  fifo_uart_tx #(.CLKS_PER_BIT(N), .PARITY_EN(1'b1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fe1), .fifo_data(fd1),
    .fifo_rd(rd1), .tx(tx1), .busy(busy1), .tx_done(done1), .frame_cnt(cnt1));

  always #5 clk = ~clk;

  assign fe0 = (wp0 == rp0);
  assign fe1 = (wp1 == rp1);

  // FIFO read port: data registered after the read strobe, ready well before WAIT ends
  always @(negedge clk) begin
    if (rd0 && wp0 != rp0) begin fd0 = mem0[rp0]; rp0 = rp0 + 1; end
    if (rd1 && wp1 != rp1) begin fd1 = mem1[rp1]; rp1 = rp1 + 1; end
  end

  always_comb begin
    tx_m   = sel ? tx1   : tx0;
    rd_m   = sel ? rd1   : rd0;
    busy_m = sel ? busy1 : busy0;
    done_m = sel ? done1 : done0;
    cnt_m  = sel ? cnt1  : cnt0;
  end

  // Loads pend into FIFO p (releasing reset on the same edge) and checks every frame.
  task automatic send_check(input bit p);
    byte unsigned exp_q [$];
    bit bits [$];
    byte unsigned d;
    int cyc, nb;
    bit bad;
    logic obs;
    sel = p;
    @(negedge clk);
    rst = 1'b1;
    exp_q = pend;
    foreach (pend[i]) begin
      if (p) begin mem1[wp1] = pend[i]; wp1 = wp1 + 1; end
      else   begin mem0[wp0] = pend[i]; wp0 = wp0 + 1; end
    end
    pend.delete();
    for (int k = 0; k < exp_q.size(); k++) begin
      d = exp_q[k];
      if (k == 0) begin
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!rd_m && cyc < 20);
        checks++;
        if (cyc != 1) begin
          errors++;
          $display("FAIL latency inst%0d: fifo_rd after %0d cycles, want 1", p, cyc);
          if (!rd_m) return;
        end
      end else begin
        @(negedge clk);
        checks++;
        if (rd_m !== 1'b1) begin
          errors++;
          $display("FAIL gap inst%0d frame%0d: fifo_rd=%b want 1 (N+3 high cycles)", p, k, rd_m);
        end
      end
      checks++;
      if (tx_m !== 1'b1 || busy_m !== 1'b1) begin
        errors++;
        $display("FAIL fetch inst%0d: tx=%b busy=%b want 1 1", p, tx_m, busy_m);
      end
      @(negedge clk);
      checks++;
      if (tx_m !== 1'b1 || rd_m !== 1'b0) begin
        errors++;
        $display("FAIL wait inst%0d: tx=%b fifo_rd=%b want 1 0", p, tx_m, rd_m);
      end
      bits.delete();
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(d[i]);
      if (p) bits.push_back(^d);
      bits.push_back(1'b1);
      nb = bits.size();
      for (int b = 0; b < nb; b++) begin
        bad = 1'b0;
        obs = bits[b];
        for (int c = 0; c < N; c++) begin
          @(negedge clk);
          if (tx_m !== bits[b] || rd_m !== 1'b0 || busy_m !== 1'b1 || done_m !== 1'b0) begin
            if (!bad) obs = tx_m;
            bad = 1'b1;
          end
          if (rand_en) en = (b == nb - 1 && c == N - 1) ? 1'b1 : 1'($urandom_range(0, 1));
        end
        checks++;
        if (bad) begin
          errors++;
          $display("FAIL bit inst%0d data=%h bit%0d: tx=%b want %b (or rd/busy/done wrong)",
                   p, d, b, obs, bits[b]);
        end
      end
      @(negedge clk);
      exp_cnt[p] = (exp_cnt[p] + 1) % 256;
      checks++;
      if (done_m !== 1'b1 || busy_m !== 1'b0 || tx_m !== 1'b1 || cnt_m !== 8'(exp_cnt[p])) begin
        errors++;
        $display("FAIL done inst%0d: tx_done=%b busy=%b tx=%b frame_cnt=%0d want 1 0 1 %0d",
                 p, done_m, busy_m, tx_m, cnt_m, exp_cnt[p]);
      end
    end
    @(negedge clk);
    checks++;
    if (done_m !== 1'b0 || rd_m !== 1'b0 || busy_m !== 1'b0) begin
      errors++;
      $display("FAIL tail inst%0d: tx_done=%b fifo_rd=%b busy=%b want 0 0 0", p, done_m, rd_m, busy_m);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx0, rd0, busy0, done0, cnt0, tx1, rd1, busy1, done1, cnt1} !== {4'b1000, 8'd0, 4'b1000, 8'd0}) begin
      errors++;
      $display("FAIL reset: tx/rd/busy/done/cnt = %b%b%b%b %0d | %b%b%b%b %0d want 1000 0 | 1000 0",
               tx0, rd0, busy0, done0, cnt0, tx1, rd1, busy1, done1, cnt1);
    end
    exp_cnt[0] = 0; exp_cnt[1] = 0;
    rst = 1'b1;
  endtask

  task automatic test_reset_midframe();
    byte unsigned d;
    int cyc;
    bit bad;
    d = 8'($urandom);
    @(negedge clk);
    en = 1'b1;
    mem0[wp0] = d; wp0 = wp0 + 1;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!rd0 && cyc < 20);
    checks++;
    if (cyc != 1) begin
      errors++;
      $display("FAIL mid_latency: fifo_rd after %0d cycles, want 1", cyc);
    end
    repeat (4 * N + 2) @(negedge clk);
    checks++;
    if (tx0 !== d[3] || busy0 !== 1'b1) begin
      errors++;
      $display("FAIL mid_bit3: tx=%b busy=%b want %b 1", tx0, busy0, d[3]);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (tx0 !== 1'b1 || busy0 !== 1'b0 || cnt0 !== 8'd0) begin
      errors++;
      $display("FAIL mid_abort: tx=%b busy=%b frame_cnt=%0d want 1 0 0", tx0, busy0, cnt0);
    end
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done0 !== 1'b0 || cnt0 !== 8'd0 || rd0 !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL mid_hold: tx_done=%b frame_cnt=%0d fifo_rd=%b want 0 0 0", done0, cnt0, rd0);
    end
    exp_cnt[0] = 0; exp_cnt[1] = 0;
    pend.push_back(8'($urandom));
    send_check(1'b0);
  endtask

  task automatic test_idle();
    bit bad;
    en = 1'b1;
    bad = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (rd0 || rd1 || !tx0 || !tx1 || busy0 || busy1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL idle_empty: rd=%b%b tx=%b%b busy=%b%b want 00 11 00", rd0, rd1, tx0, tx1, busy0, busy1);
    end
    en = 1'b0;
    mem0[wp0] = 8'h5A; wp0 = wp0 + 1;
    bad = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (rd0 || !tx0 || busy0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL idle_en0: rd=%b tx=%b busy=%b want 0 1 0", rd0, tx0, busy0);
    end
    wp0 = rp0;
    en = 1'b1;
  endtask

  task automatic test_basic();
    pend.push_back(8'hA5);
    send_check(1'b0);
  endtask

  task automatic test_parity();
    pend.push_back(8'h07);
    send_check(1'b1);
  endtask

  task automatic test_back_to_back();
    pend.push_back(8'h11);
    pend.push_back(8'h22);
    send_check(1'b0);
  endtask

  task automatic test_random();
    rand_en = 1'b1;
    repeat (5) pend.push_back(8'($urandom));
    send_check(1'b0);
    repeat (4) pend.push_back(8'($urandom));
    send_check(1'b1);
    rand_en = 1'b0;
    en = 1'b1;
  endtask

  task automatic test_wrap();
    int n;
    n = 256 - exp_cnt[1];
    repeat (n) pend.push_back(8'($urandom));
    send_check(1'b1);
    checks++;
    if (cnt1 !== 8'd0) begin
      errors++;
      $display("FAIL wrap: frame_cnt=%0d want 0", cnt1);
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0;
    fd0 = 8'h00; fd1 = 8'h00;
    test_reset();
    test_reset_midframe();
    test_idle();
    test_basic();
    test_parity();
    test_back_to_back();
    test_random();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 8, clock cycles per serial bit period; legal range 2..255.
REQ-002 Parameter PARITY_EN, default 0, when 1 inserts an even-parity bit between data bit 7 and the stop bit.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  asynchronous, active-low reset.
REQ-005 Port en  input  1  high permits starting new frames; a frame already in progress always completes.
REQ-006 Port fifo_empty  input  1  empty flag from the upstream sync FIFO.
REQ-007 Port fifo_data  input  8  FIFO registered read data, valid one clock after a fifo_rd acceptance.
REQ-008 Port fifo_rd  output  1  one-cycle read strobe to the FIFO.
REQ-009 Port tx  output  1  serial line, idle high, LSB first.
REQ-010 Port busy  output  1  high in every state except IDLE.
REQ-011 Port tx_done  output  1  one-cycle pulse at frame completion.
REQ-012 Port frame_cnt  output  8  count of completed frames, modulo 256.

Function
REQ-013 The FSM SHALL have states IDLE, FETCH, WAIT, START, DATA, PARITY, STOP; all outputs registered or decoded from state only.
REQ-014 IDLE: when en=1 and fifo_empty=0 at an edge, the FSM SHALL go to FETCH; otherwise it SHALL remain in IDLE.
REQ-015 FETCH: fifo_rd SHALL be 1 for exactly this one cycle; next state WAIT, unconditionally.
REQ-016 WAIT: at its ending edge, the FSM SHALL load fifo_data into an 8-bit shift register, clear the parity accumulator, and go to START.
REQ-017 fifo_rd SHALL be 0 in every state other than FETCH; there is exactly one fifo_rd per transmitted frame.
REQ-018 START SHALL drive tx=0 for CLKS_PER_BIT cycles, then go to DATA.
REQ-019 DATA SHALL drive shift-register bit 0 on tx for CLKS_PER_BIT cycles per bit, shifting right and XOR-accumulating parity after each bit.
REQ-020 DATA SHALL send 8 bits via a 3-bit index; after bit 7, the FSM SHALL go to PARITY if PARITY_EN=1, else to STOP.
REQ-021 PARITY SHALL drive the XOR of the 8 data bits for CLKS_PER_BIT cycles, then go to STOP.
REQ-022 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles; at its final edge the FSM SHALL go to IDLE, pulse tx_done for the following cycle, and increment frame_cnt.
REQ-023 A baud counter SHALL count 0..CLKS_PER_BIT-1 in START, DATA, PARITY and STOP; it SHALL clear on each bit boundary and on every state change.
REQ-024 tx SHALL be 1 in IDLE, FETCH and WAIT.
REQ-025 Latency: tx SHALL fall exactly 2 clocks after the IDLE edge that samples fifo_empty=0 with en=1.
REQ-026 Back-to-back: with the FIFO non-empty, the line SHALL be high for CLKS_PER_BIT+3 cycles between the last data/parity bit and the next start bit.
REQ-027 Changes on en or fifo_empty outside IDLE SHALL be ignored.
REQ-028 frame_cnt SHALL wrap from 255 to 0 without saturating.

Reset
REQ-029 While rst=0, and asynchronously on its assertion: state IDLE, tx=1, fifo_rd=0, busy=0, tx_done=0, frame_cnt=0, and all counters and the shift register cleared.
REQ-030 A reset asserted mid-frame SHALL abort the frame, with no tx_done pulse and no frame_cnt increment.
REQ-031 After rst deasserts, the first state transition SHALL occur at the next rising edge.

Verification (CLKS_PER_BIT=4)
REQ-032 FIFO holds 0xA5, en=1, PARITY_EN=0 -> one fifo_rd pulse; tx bits 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles total); one tx_done pulse; frame_cnt=1.
REQ-033 FIFO holds 0x07, PARITY_EN=1 -> tx bits 0,1,1,1,0,0,0,0,0,1(parity),1(stop), 44 cycles total.
REQ-034 FIFO holds 0x11 then 0x22 -> exactly two fifo_rd pulses; the line stays high for 7 cycles between frames; frame_cnt=2.
REQ-035 fifo_empty=1, or en=0 with a non-empty FIFO, for 100 cycles -> fifo_rd never 1, tx=1, busy=0.
REQ-036 rst=0 asserted during DATA bit 3 -> tx=1 and busy=0 immediately; frame_cnt unchanged at 0; after release with the FIFO non-empty, a fresh frame starts 2 cycles after the first IDLE sample.
REQ-037 Preset 255 completed frames, then send one more -> frame_cnt reads 0.
